// File: rtl/ppu_pipe_pkg.sv
// Shared types for the PPU pipeline-control core: NOP encoding, stage metadata
// and the per-stage update action.
package ppu_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // The control bundle travels beside this struct because its width is a
  // parameter of the core.
  typedef struct packed {
    logic [4:0] rd;
    logic       load;
    logic       valid;
  } stage_meta_t;

  localparam stage_meta_t BUBBLE_META = '{rd: 5'd0, load: 1'b0, valid: 1'b0};

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_SHIFT,
    ACT_LOAD
  } stage_act_e;

endpackage

// File: rtl/ppu_pipeline_ctrl_if.sv
// Fetch, decode, redirect and stage-bundle signals of the pipeline-control core.
interface ppu_pipeline_ctrl_if #(
  parameter int XLEN       = 32,
  parameter int CTRL_W     = 32,
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 16
);
  logic [XLEN-1:0]              Instr_In;
  logic [XLEN-1:0]              PC_Out;
  logic [XLEN-1:0]              IF_ID_Instr;
  logic                         IF_ID_Valid;
  logic [CTRL_W-1:0]            ID_Ctrl_In;
  logic                         ID_Load_Instr;
  logic [4:0]                   ID_rs1;
  logic [4:0]                   ID_rs2;
  logic [4:0]                   ID_rd;
  logic                         Branch_Taken;
  logic [XLEN-1:0]              Branch_Target;
  logic                         Ext_Stall;
  logic [NUM_STAGES*CTRL_W-1:0] Stage_Ctrl;
  logic [NUM_STAGES*5-1:0]      Stage_Rd;
  logic [NUM_STAGES-1:0]        Stage_Valid;
  logic                         Hazard_Stall;
  logic                         Flush;
  logic [CNT_W-1:0]             Stall_Count;
  logic [CNT_W-1:0]             Flush_Count;

  modport master (
    output Instr_In, ID_Ctrl_In, ID_Load_Instr, ID_rs1, ID_rs2, ID_rd,
           Branch_Taken, Branch_Target, Ext_Stall,
    input  PC_Out, IF_ID_Instr, IF_ID_Valid, Stage_Ctrl, Stage_Rd, Stage_Valid,
           Hazard_Stall, Flush, Stall_Count, Flush_Count
  );

  modport slave (
    input  Instr_In, ID_Ctrl_In, ID_Load_Instr, ID_rs1, ID_rs2, ID_rd,
           Branch_Taken, Branch_Target, Ext_Stall,
    output PC_Out, IF_ID_Instr, IF_ID_Valid, Stage_Ctrl, Stage_Rd, Stage_Valid,
           Hazard_Stall, Flush, Stall_Count, Flush_Count
  );
endinterface

// File: rtl/ppu_stage_reg.sv
// One post-ID pipeline register: holds, takes a bubble, or captures its input.
module ppu_stage_reg
  import ppu_pipe_pkg::*;
#(
  parameter int CTRL_W = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  stage_act_e        act,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  stage_meta_t       d_meta,
  output logic [CTRL_W-1:0] q_ctrl,
  output stage_meta_t       q_meta
);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      q_ctrl <= '0;
      q_meta <= BUBBLE_META;
    end else begin
      case (act)
        ACT_BUBBLE: begin
          q_ctrl <= '0;
          q_meta <= BUBBLE_META;
        end
        ACT_SHIFT, ACT_LOAD: begin
          q_ctrl <= d_ctrl;
          q_meta <= d_meta;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/ppu_pipeline_ctrl.sv
// PPU pipeline control: PC, IF/ID register, post-ID stage chain, load-use
// stall, branch flush, external freeze and saturating event counters.
module ppu_pipeline_ctrl
  import ppu_pipe_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              CTRL_W     = 32,
  parameter int              NUM_STAGES = 3,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              CNT_W      = 16
) (
  input  logic clk,
  input  logic Reset,
  ppu_pipeline_ctrl_if.slave bus
);

  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   ifid_instr_q;
  logic              ifid_valid_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic [CTRL_W-1:0] st_ctrl [NUM_STAGES];
  stage_meta_t       st_meta [NUM_STAGES];

  logic              hazard;
  logic              flush;
  logic              hz_stall;
  stage_act_e        head_act;
  stage_act_e        tail_act;
  logic [CTRL_W-1:0] entry_ctrl;
  stage_meta_t       entry_meta;

  logic [NUM_STAGES*CTRL_W-1:0] stage_ctrl_flat;
  logic [NUM_STAGES*5-1:0]      stage_rd_flat;
  logic [NUM_STAGES-1:0]        stage_valid_flat;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    hazard = st_meta[0].valid && st_meta[0].load && (st_meta[0].rd != 5'd0) &&
             ifid_valid_q &&
             ((st_meta[0].rd == bus.ID_rs1) || (st_meta[0].rd == bus.ID_rs2));
    flush    = bus.Branch_Taken && !bus.Ext_Stall;
    hz_stall = hazard && !bus.Ext_Stall && !bus.Branch_Taken;

    head_act = ACT_LOAD;
    tail_act = ACT_SHIFT;
    if (bus.Ext_Stall) begin
      head_act = ACT_HOLD;
      tail_act = ACT_HOLD;
    end else if (flush || hz_stall) begin
      head_act = ACT_BUBBLE;
    end

    // An empty IF/ID still passes rd/load through, but never a live control bundle.
    entry_ctrl = ifid_valid_q ? bus.ID_Ctrl_In : '0;
    entry_meta = '{rd: bus.ID_rd, load: bus.ID_Load_Instr, valid: ifid_valid_q};
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= XLEN'(NOP_INSTR);
      ifid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else if (!bus.Ext_Stall) begin
      if (flush) begin
        pc_q         <= bus.Branch_Target;
        ifid_instr_q <= XLEN'(NOP_INSTR);
        ifid_valid_q <= 1'b0;
        flush_cnt_q  <= sat_inc(flush_cnt_q);
      end else if (hz_stall) begin
        stall_cnt_q  <= sat_inc(stall_cnt_q);
      end else begin
        pc_q         <= pc_q + XLEN'(4);
        ifid_instr_q <= bus.Instr_In;
        ifid_valid_q <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      ppu_stage_reg #(.CTRL_W(CTRL_W)) u_stage (
        .clk    (clk),
        .rst_b  (Reset),
        .act    (head_act),
        .d_ctrl (entry_ctrl),
        .d_meta (entry_meta),
        .q_ctrl (st_ctrl[k]),
        .q_meta (st_meta[k])
      );
    end else begin : g_tail
      ppu_stage_reg #(.CTRL_W(CTRL_W)) u_stage (
        .clk    (clk),
        .rst_b  (Reset),
        .act    (tail_act),
        .d_ctrl (st_ctrl[k-1]),
        .d_meta (st_meta[k-1]),
        .q_ctrl (st_ctrl[k]),
        .q_meta (st_meta[k])
      );
    end
  end

  always_comb begin
    stage_ctrl_flat  = '0;
    stage_rd_flat    = '0;
    stage_valid_flat = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      stage_ctrl_flat[k*CTRL_W +: CTRL_W] = st_ctrl[k];
      stage_rd_flat[k*5 +: 5]             = st_meta[k].rd;
      stage_valid_flat[k]                 = st_meta[k].valid;
    end
  end

  assign bus.PC_Out       = pc_q;
  assign bus.IF_ID_Instr  = ifid_instr_q;
  assign bus.IF_ID_Valid  = ifid_valid_q;
  assign bus.Stage_Ctrl   = stage_ctrl_flat;
  assign bus.Stage_Rd     = stage_rd_flat;
  assign bus.Stage_Valid  = stage_valid_flat;
  assign bus.Hazard_Stall = hz_stall;
  assign bus.Flush        = flush;
  assign bus.Stall_Count  = stall_cnt_q;
  assign bus.Flush_Count  = flush_cnt_q;

endmodule

// File: tb/tb_ppu_pipeline_ctrl.sv
// Bench for ppu_pipeline_ctrl: a cycle model pushes expected state per edge,
// observed state is queued alongside, and each scenario drains and compares.
module tb_ppu_pipeline_ctrl;
  import ppu_pipe_pkg::*;

  localparam int XL   = 32;
  localparam int CW   = 8;
  localparam int NS   = 3;
  localparam int CNTW = 2;

  typedef struct packed {
    logic [XL-1:0]    pc;
    logic [XL-1:0]    ins;
    logic             ifv;
    logic [NS*CW-1:0] ctrl;
    logic [NS*5-1:0]  rd;
    logic [NS-1:0]    v;
    logic [CNTW-1:0]  sc;
    logic [CNTW-1:0]  fc;
    logic             hs;
    logic             fl;
  } obs_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic pre_hs, pre_fl;
  obs_t sb [$];
  obs_t oq [$];

  logic [XL-1:0]   m_pc, m_ins;
  logic            m_ifv;
  logic [CW-1:0]   m_ctrl [NS];
  logic [4:0]      m_rd   [NS];
  logic            m_ld   [NS];
  logic            m_v    [NS];
  logic [CNTW-1:0] m_sc, m_fc;

  ppu_pipeline_ctrl_if #(.XLEN(XL), .CTRL_W(CW), .NUM_STAGES(NS), .CNT_W(CNTW)) bus ();

  ppu_pipeline_ctrl #(.XLEN(XL), .CTRL_W(CW), .NUM_STAGES(NS), .RESET_PC('0), .CNT_W(CNTW)) dut (
    .clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    obs_t e, o;
    logic hz, fl, hs;
    bus.Instr_In = {m_pc[29:0], 2'b11};
    #1;
    hz = m_v[0] && m_ld[0] && (m_rd[0] != 5'd0) && m_ifv &&
         (m_rd[0] == bus.ID_rs1 || m_rd[0] == bus.ID_rs2);
    fl = bus.Branch_Taken && !bus.Ext_Stall;
    hs = hz && !bus.Ext_Stall && !bus.Branch_Taken;
    pre_hs = bus.Hazard_Stall;
    pre_fl = bus.Flush;
    if (!rst_n) begin
      m_pc = '0; m_ins = 32'h13; m_ifv = 1'b0; m_sc = '0; m_fc = '0;
      for (int k = 0; k < NS; k++) begin
        m_ctrl[k] = '0; m_rd[k] = '0; m_ld[k] = 1'b0; m_v[k] = 1'b0;
      end
    end else if (!bus.Ext_Stall) begin
      for (int k = NS - 1; k >= 1; k--) begin
        m_ctrl[k] = m_ctrl[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1]; m_v[k] = m_v[k-1];
      end
      if (fl || hs) begin
        m_ctrl[0] = '0; m_rd[0] = '0; m_ld[0] = 1'b0; m_v[0] = 1'b0;
      end else begin
        m_ctrl[0] = m_ifv ? bus.ID_Ctrl_In : '0;
        m_rd[0] = bus.ID_rd; m_ld[0] = bus.ID_Load_Instr; m_v[0] = m_ifv;
      end
      if (fl) begin
        m_pc = bus.Branch_Target; m_ins = 32'h13; m_ifv = 1'b0;
        if (m_fc != '1) m_fc = m_fc + 1'b1;
      end else if (hs) begin
        if (m_sc != '1) m_sc = m_sc + 1'b1;
      end else begin
        m_pc = m_pc + 32'd4; m_ins = bus.Instr_In; m_ifv = 1'b1;
      end
    end
    e.pc = m_pc; e.ins = m_ins; e.ifv = m_ifv; e.sc = m_sc; e.fc = m_fc; e.hs = hs; e.fl = fl;
    for (int k = 0; k < NS; k++) begin
      e.ctrl[k*CW +: CW] = m_ctrl[k]; e.rd[k*5 +: 5] = m_rd[k]; e.v[k] = m_v[k];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    o.pc = bus.PC_Out; o.ins = bus.IF_ID_Instr; o.ifv = bus.IF_ID_Valid;
    o.ctrl = bus.Stage_Ctrl; o.rd = bus.Stage_Rd; o.v = bus.Stage_Valid;
    o.sc = bus.Stall_Count; o.fc = bus.Flush_Count; o.hs = pre_hs; o.fl = pre_fl;
    oq.push_back(o);
  endtask

  task automatic idle_inputs();
    bus.ID_Ctrl_In = CW'($urandom); bus.ID_Load_Instr = 1'b0;
    bus.ID_rs1 = 5'd0; bus.ID_rs2 = 5'd0; bus.ID_rd = 5'd7;
    bus.Branch_Taken = 1'b0; bus.Branch_Target = '0; bus.Ext_Stall = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    idle_inputs();
    rst_n = 1'b0; tick(); tick();
    total++; if (bus.PC_Out !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", bus.PC_Out, 32'h0); end
    total++; if (bus.IF_ID_Instr !== 32'h13 || bus.IF_ID_Valid !== 1'b0) begin
      bad++; $display("FAIL reset_ifid: got %h/%b want 00000013/0", bus.IF_ID_Instr, bus.IF_ID_Valid); end
    total++; if (bus.Stage_Valid !== '0 || bus.Stage_Ctrl !== '0 || bus.Stall_Count !== '0 || bus.Flush_Count !== '0) begin
      bad++; $display("FAIL reset_stages: got v=%b c=%h sc=%0d fc=%0d want zeros", bus.Stage_Valid, bus.Stage_Ctrl, bus.Stall_Count, bus.Flush_Count); end
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (bus.PC_Out !== 32'(4 * i)) begin bad++; $display("FAIL reset_pc_seq: got %h want %h", bus.PC_Out, 32'(4 * i)); end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = oq.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL reset_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_load_use();
    obs_t e, o;
    logic [XL-1:0] pc_keep, ins_keep;
    reset_dut(); tick();
    bus.ID_Load_Instr = 1'b1; bus.ID_rd = 5'd5; tick();
    bus.ID_Load_Instr = 1'b0; bus.ID_rd = 5'd7; bus.ID_rs1 = 5'd1; bus.ID_rs2 = 5'd5;
    pc_keep = m_pc; ins_keep = m_ins;
    tick();
    total++; if (pre_hs !== 1'b1) begin bad++; $display("FAIL lu_stall: got %b want 1", pre_hs); end
    total++; if (bus.PC_Out !== pc_keep || bus.IF_ID_Instr !== ins_keep) begin
      bad++; $display("FAIL lu_hold: got %h/%h want %h/%h", bus.PC_Out, bus.IF_ID_Instr, pc_keep, ins_keep); end
    total++; if (bus.Stage_Valid[0] !== 1'b0 || bus.Stall_Count !== 2'd1) begin
      bad++; $display("FAIL lu_bubble: got v0=%b sc=%0d want 0/1", bus.Stage_Valid[0], bus.Stall_Count); end
    tick();
    total++; if (pre_hs !== 1'b0) begin bad++; $display("FAIL lu_once: got %b want 0", pre_hs); end
    bus.ID_Load_Instr = 1'b1; bus.ID_rd = 5'd0; bus.ID_rs2 = 5'd0; tick();
    bus.ID_Load_Instr = 1'b0; bus.ID_rd = 5'd7; tick();
    total++; if (pre_hs !== 1'b0 || bus.Stall_Count !== 2'd1) begin
      bad++; $display("FAIL lu_rd0: got hs=%b sc=%0d want 0/1", pre_hs, bus.Stall_Count); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = oq.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL load_use_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_branch();
    obs_t e, o;
    reset_dut(); tick();
    bus.ID_Load_Instr = 1'b1; bus.ID_rd = 5'd5; tick();
    bus.ID_Load_Instr = 1'b0; bus.ID_rd = 5'd7; bus.ID_rs2 = 5'd5;
    bus.Branch_Taken = 1'b1; bus.Branch_Target = 32'h100;
    tick();
    total++; if (pre_fl !== 1'b1 || pre_hs !== 1'b0) begin
      bad++; $display("FAIL br_comb: got fl=%b hs=%b want 1/0", pre_fl, pre_hs); end
    total++; if (bus.PC_Out !== 32'h100 || bus.IF_ID_Valid !== 1'b0 || bus.Stage_Valid[0] !== 1'b0) begin
      bad++; $display("FAIL br_redirect: got pc=%h ifv=%b v0=%b want 00000100/0/0", bus.PC_Out, bus.IF_ID_Valid, bus.Stage_Valid[0]); end
    total++; if (bus.Flush_Count !== 2'd1 || bus.Stall_Count !== 2'd0) begin
      bad++; $display("FAIL br_counts: got fc=%0d sc=%0d want 1/0", bus.Flush_Count, bus.Stall_Count); end
    idle_inputs(); tick();
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = oq.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL branch_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_ext_stall();
    obs_t e, o;
    logic [XL-1:0] pc_keep, ins_keep;
    reset_dut(); tick(); tick();
    pc_keep = m_pc; ins_keep = m_ins;
    bus.Ext_Stall = 1'b1; bus.Branch_Taken = 1'b1; bus.Branch_Target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      bus.ID_Ctrl_In = CW'($urandom);
      tick();
      total++; if (pre_fl !== 1'b0 || bus.PC_Out !== pc_keep || bus.IF_ID_Instr !== ins_keep || bus.Flush_Count !== 2'd0) begin
        bad++; $display("FAIL xs_frozen: got fl=%b pc=%h ins=%h fc=%0d want 0/%h/%h/0", pre_fl, bus.PC_Out, bus.IF_ID_Instr, bus.Flush_Count, pc_keep, ins_keep); end
    end
    bus.Ext_Stall = 1'b0; tick();
    total++; if (pre_fl !== 1'b1 || bus.PC_Out !== 32'h200 || bus.Flush_Count !== 2'd1) begin
      bad++; $display("FAIL xs_release: got fl=%b pc=%h fc=%0d want 1/00000200/1", pre_fl, bus.PC_Out, bus.Flush_Count); end
    idle_inputs(); tick();
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = oq.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL ext_stall_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_wrap_sat();
    obs_t e, o;
    reset_dut(); tick();
    bus.Branch_Taken = 1'b1; bus.Branch_Target = 32'hFFFF_FFFC; tick();
    total++; if (bus.PC_Out !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_target: got %h want fffffffc", bus.PC_Out); end
    bus.Branch_Taken = 1'b0; tick();
    total++; if (bus.PC_Out !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want 00000000", bus.PC_Out); end
    for (int i = 0; i < 4; i++) begin
      bus.ID_Load_Instr = 1'b1; bus.ID_rd = 5'd3; bus.ID_rs1 = 5'd0; tick();
      bus.ID_Load_Instr = 1'b0; bus.ID_rd = 5'd9; bus.ID_rs1 = 5'd3; tick();
    end
    total++; if (bus.Stall_Count !== 2'd3) begin bad++; $display("FAIL sat_stall: got %0d want 3", bus.Stall_Count); end
    idle_inputs();
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = oq.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL wrap_sat_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_mid_stall();
    obs_t e, o;
    reset_dut(); tick();
    bus.ID_Load_Instr = 1'b1; bus.ID_rd = 5'd5; tick();
    bus.ID_Load_Instr = 1'b0; bus.ID_rd = 5'd7; bus.ID_rs1 = 5'd5;
    rst_n = 1'b0; tick();
    total++; if (pre_hs !== 1'b1) begin bad++; $display("FAIL rms_stall: got %b want 1", pre_hs); end
    total++; if (bus.PC_Out !== 32'h0 || bus.IF_ID_Instr !== 32'h13 || bus.IF_ID_Valid !== 1'b0 ||
                 bus.Stage_Valid !== '0 || bus.Stage_Rd !== '0 || bus.Stall_Count !== '0) begin
      bad++; $display("FAIL rms_state: got pc=%h ins=%h ifv=%b v=%b rd=%h sc=%0d want reset values",
                      bus.PC_Out, bus.IF_ID_Instr, bus.IF_ID_Valid, bus.Stage_Valid, bus.Stage_Rd, bus.Stall_Count); end
    rst_n = 1'b1; idle_inputs(); tick();
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = oq.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL reset_mid_stall_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      rst_n             = ($urandom_range(0, 63) != 0);
      bus.Ext_Stall     = ($urandom_range(0, 7) == 0);
      bus.Branch_Taken  = ($urandom_range(0, 9) == 0);
      bus.Branch_Target = {$urandom_range(0, 255), 2'b00};
      bus.ID_Load_Instr = ($urandom_range(0, 2) == 0);
      bus.ID_rd         = 5'($urandom_range(0, 3));
      bus.ID_rs1        = 5'($urandom_range(0, 3));
      bus.ID_rs2        = 5'($urandom_range(0, 3));
      bus.ID_Ctrl_In    = CW'($urandom);
      tick();
      e = sb.pop_front(); o = oq.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL random_sb cycle %0d: got %h want %h", i, o, e); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    m_pc = '0; m_ins = 32'h13; m_ifv = 1'b0; m_sc = '0; m_fc = '0;
    for (int k = 0; k < NS; k++) begin
      m_ctrl[k] = '0; m_rd[k] = '0; m_ld[k] = 1'b0; m_v[k] = 1'b0;
    end
    rst_n = 1'b0;
    idle_inputs();
    bus.Instr_In = '0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_branch();
    test_ext_stall();
    test_wrap_sat();
    test_reset_mid_stall();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
